// File: rtl/vc_link_arbiter.sv
// Credit-based round-robin scheduler that shares one output link among NUM_VC virtual channels.
// Pops one eligible VC buffer per cycle and registers its head flit onto the link.
module vc_link_arbiter #(
    parameter int unsigned NUM_VC  = 4,
    parameter int unsigned VCW     = 2,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned CREDITS = 32,
    parameter int unsigned CW      = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [NUM_VC-1:0]          vc_empty,
    input  logic [NUM_VC*DWIDTH-1:0]   vc_data,
    input  logic [NUM_VC-1:0]          credit_in,
    output logic [NUM_VC-1:0]          vc_read_en,
    output logic                       link_valid,
    output logic [DWIDTH-1:0]          link_data,
    output logic [VCW-1:0]             link_vc,
    output logic                       credit_err
);

    localparam logic [CW-1:0]  CreditMax = CW'(CREDITS);
    localparam logic [VCW-1:0] LastInit  = VCW'(NUM_VC - 1);

    logic [NUM_VC-1:0][CW-1:0] credit_q, credit_d;
    logic [VCW-1:0]            last_q;
    logic                      link_valid_q;
    logic [DWIDTH-1:0]         link_data_q;
    logic [VCW-1:0]            link_vc_q;
    logic                      credit_err_q;

    logic [NUM_VC-1:0]         eligible;
    logic [NUM_VC-1:0]         grant_oh;
    logic [NUM_VC-1:0]         overflow;
    logic                      grant_valid;
    logic [VCW-1:0]            grant_idx;
    logic [VCW-1:0]            cand;
    logic [DWIDTH-1:0]         grant_data;

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            eligible[i] = ~vc_empty[i] & (credit_q[i] != '0) & en;
        end
    end

    // Search starts one past the last winner; VCW-bit addition wraps modulo NUM_VC.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_q;
        cand        = last_q;
        for (int k = 1; k <= NUM_VC; k++) begin
            cand = last_q + VCW'(k);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_oh   = '0;
        grant_data = '0;
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_VC; i++) begin
            if (grant_oh[i]) begin
                grant_data = vc_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Buffers must not pop while reset is held.
    always_comb begin
        vc_read_en = reset ? grant_oh : '0;
    end

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            credit_d[i] = credit_q[i];
            overflow[i] = 1'b0;
            if (credit_in[i] && !grant_oh[i]) begin
                if (credit_q[i] == CreditMax) begin
                    overflow[i] = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CW'(1);
                end
            end else if (grant_oh[i] && !credit_in[i]) begin
                credit_d[i] = credit_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q     <= {NUM_VC{CreditMax}};
            last_q       <= LastInit;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            link_vc_q    <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            credit_err_q <= |overflow;
            link_valid_q <= grant_valid;
            if (grant_valid) begin
                link_data_q <= grant_data;
                link_vc_q   <= grant_idx;
                last_q      <= grant_idx;
            end
        end
    end

    assign link_valid = link_valid_q;
    assign link_data  = link_data_q;
    assign link_vc    = link_vc_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_vc_link_arbiter.sv
// Scoreboard bench for vc_link_arbiter: per-VC upstream queues and credits modelled with plain
// integers; expected flits are queued at grant time and popped by a link monitor.
module tb_vc_link_arbiter;

    localparam int NV  = 4;
    localparam int VW  = 2;
    localparam int DW  = 32;
    localparam int CR  = 32;
    localparam int CWD = 6;
    localparam int MEM = 4096;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [NV-1:0]     vc_empty;
    logic [NV*DW-1:0]  vc_data;
    logic [NV-1:0]     credit_in;
    logic [NV-1:0]     vc_read_en;
    logic              link_valid;
    logic [DW-1:0]     link_data;
    logic [VW-1:0]     link_vc;
    logic              credit_err;

    vc_link_arbiter #(
        .NUM_VC (NV),
        .VCW    (VW),
        .DWIDTH (DW),
        .CREDITS(CR),
        .CW     (CWD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .vc_empty  (vc_empty),
        .vc_data   (vc_data),
        .credit_in (credit_in),
        .vc_read_en(vc_read_en),
        .link_valid(link_valid),
        .link_data (link_data),
        .link_vc   (link_vc),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Upstream buffers: per-VC circular-free arrays indexed by head/tail.
    logic [DW-1:0] mem [NV][MEM];
    int            head [NV];
    int            tail [NV];
    int            seq  [NV];

    // Reference model state.
    int  cred [NV];
    int  last;
    bit  exp_valid;
    bit  exp_err;
    logic [VW+DW-1:0] exp_q [$];

    logic [NV-1:0] cin;
    logic          en_v;
    logic [NV-1:0] last_rd;
    int            flits_seen [NV];
    int            err_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_flit(input int v);
        mem[v][tail[v]] = 32'hA000_0000 | (DW'(seq[v]) << 4) | DW'(v);
        tail[v]++;
        seq[v]++;
    endtask

    task automatic clear_bufs();
        for (int v = 0; v < NV; v++) head[v] = tail[v];
    endtask

    task automatic drive();
        for (int v = 0; v < NV; v++) begin
            vc_empty[v] = (head[v] == tail[v]);
            vc_data[v*DW +: DW] = vc_empty[v] ? DW'($urandom) : mem[v][head[v]];
        end
        credit_in = cin;
        en        = en_v;
    endtask

    // One clock: entered just after a rising edge, returns just after the next one.
    task automatic cycle();
        bit grant;
        int g;
        bit ovf;
        drive();
        #2;
        grant = 1'b0;
        g     = 0;
        for (int k = 1; k <= NV; k++) begin
            int v;
            v = (last + k) % NV;
            if (!grant && en_v && head[v] != tail[v] && cred[v] > 0) begin
                grant = 1'b1;
                g     = v;
            end
        end
        last_rd = vc_read_en;
        chk("vc_read_en", 64'(vc_read_en), grant ? (64'd1 << g) : 64'd0);
        if (grant) exp_q.push_back({VW'(g), mem[g][head[g]]});
        @(posedge clk);
        ovf = 1'b0;
        for (int v = 0; v < NV; v++) begin
            bit dec;
            dec = grant && (g == v);
            if (cin[v] && !dec) begin
                if (cred[v] == CR) ovf = 1'b1;
                else cred[v]++;
            end else if (dec && !cin[v]) begin
                cred[v]--;
            end
        end
        exp_valid = grant;
        exp_err   = ovf;
        if (grant) begin
            head[g]++;
            last = g;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) cred[v] = CR;
        last      = NV - 1;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_q.delete();
    endtask

    // Entered just after a rising edge; asserts reset asynchronously mid-cycle.
    task automatic do_reset();
        reset = 1'b0;
        drive();
        #1;
        chk("rst_vc_read_en", 64'(vc_read_en), 64'd0);
        chk("rst_link_valid", 64'(link_valid), 64'd0);
        chk("rst_link_data", 64'(link_data), 64'd0);
        chk("rst_link_vc", 64'(link_vc), 64'd0);
        chk("rst_credit_err", 64'(credit_err), 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [VW+DW-1:0] mon_e;
    always @(negedge clk) begin
        if (reset) begin
            chk("link_valid", 64'(link_valid), 64'(exp_valid));
            chk("credit_err", 64'(credit_err), 64'(exp_err));
            if (credit_err) err_seen++;
            if (link_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("link_vc", 64'(link_vc), 64'(mon_e[DW +: VW]));
                    chk("link_data", 64'(link_data), 64'(mon_e[DW-1:0]));
                    flits_seen[link_vc]++;
                end
            end
        end
    end

    initial begin
        int base;
        for (int v = 0; v < NV; v++) begin
            head[v] = 0;
            tail[v] = 0;
            seq[v]  = 0;
            flits_seen[v] = 0;
        end
        err_seen = 0;
        cin      = '0;
        en_v     = 1'b0;
        reset    = 1'b0;
        model_reset();
        drive();
        #1;
        chk("init_vc_read_en", 64'(vc_read_en), 64'd0);
        chk("init_link_valid", 64'(link_valid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Round-robin with all VCs busy, then with VC1 drained.
        for (int v = 0; v < NV; v++) for (int n = 0; n < 8; n++) push_flit(v);
        en_v = 1'b1;
        for (int c = 0; c < 12; c++) cycle();
        head[1] = tail[1];
        for (int c = 0; c < 9; c++) cycle();

        // Reset in the middle of traffic; first grant afterwards must be VC0.
        head[1] = tail[1] - 3;
        do_reset();
        cycle();
        chk("first_grant_vc0", 64'(last_rd), 64'd1);
        for (int c = 0; c < 4; c++) cycle();

        // Single-VC credit exhaustion and one-credit refill.
        clear_bufs();
        do_reset();
        for (int n = 0; n < 40; n++) push_flit(2);
        base = flits_seen[2];
        for (int c = 0; c < 36; c++) cycle();
        chk("vc2_exhaust_count", 64'(flits_seen[2] - base), 64'd32);
        cin = 4'b0100;
        cycle();
        cin = '0;
        for (int c = 0; c < 3; c++) cycle();
        chk("vc2_refill_count", 64'(flits_seen[2] - base), 64'd33);

        // Grant and credit return on the same VC, then overflow on an idle VC.
        clear_bufs();
        do_reset();
        for (int n = 0; n < 10; n++) push_flit(0);
        base = err_seen;
        cin = 4'b0001;
        for (int c = 0; c < 6; c++) cycle();
        cin = '0;
        chk("simul_no_err", 64'(err_seen - base), 64'd0);
        en_v = 1'b0;
        cin  = 4'b1000;
        cycle();
        cin = '0;
        for (int c = 0; c < 3; c++) cycle();
        chk("overflow_err_pulses", 64'(err_seen - base), 64'd1);

        // Randomised traffic.
        clear_bufs();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int v = 0; v < NV; v++) if ($urandom_range(3) == 0) push_flit(v);
            for (int v = 0; v < NV; v++) cin[v] = ($urandom_range(4) == 0);
            en_v = ($urandom_range(9) != 0);
            cycle();
        end

        en_v = 1'b0;
        cin  = '0;
        for (int c = 0; c < 3; c++) cycle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_link_arbiter.md
# vc_link_arbiter

Round-robin, credit-based scheduler sharing one output link among NUM_VC virtual-channel buffers of a router output port. Each cycle it picks one VC that is non-empty and holds a downstream credit, pops that buffer's head flit, and drives it onto the link with its VC id. It keeps one credit counter per VC, mirroring free slots in the downstream VC buffers, so the downstream buffers never overflow.

## Interface
- NUM_VC, 4: number of VCs; power of two, 2..8
- VCW, 2: log2(NUM_VC); width of VC id
- DWIDTH, 32: flit width
- CREDITS, 32: downstream buffer depth per VC; initial and maximum credit count
- CW, 6: credit counter width; must hold CREDITS
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- en  in  1  scheduler enable; 0 = no grant this cycle
- vc_empty  in  NUM_VC  per-VC buffer empty flag
- vc_data  in  NUM_VC*DWIDTH  per-VC head flit; VC i at [i*DWIDTH +: DWIDTH]
- credit_in  in  NUM_VC  one-cycle pulse per freed downstream slot, per VC
- vc_read_en  out  NUM_VC  one-hot pop strobe to the granted buffer (combinational)
- link_valid  out  1  registered; link_data/link_vc valid
- link_data  out  DWIDTH  registered flit
- link_vc  out  VCW  registered VC id of link_data
- credit_err  out  1  registered one-cycle pulse on credit overflow

## Operation
- eligible[i] = ~vc_empty[i] & (credit[i] != 0) & en.
- Round-robin pointer `last` holds the last granted VC. Search order: last+1, last+2, … modulo NUM_VC. First eligible VC wins (g).
- If any VC is eligible, vc_read_en = one-hot(g). Otherwise vc_read_en = 0. At most one bit is ever set.
- On the clock edge with a grant:
  - link_data <= vc_data[g]
  - link_vc <= g
  - link_valid <= 1
  - last <= g
  - credit[g] decrements unless credit_in[g] is also set
- No grant: link_valid <= 0. link_data and link_vc hold their previous values. last is unchanged.
- Credit update per VC, each edge:
  - dec only: credit - 1
  - credit_in only: credit + 1
  - both: unchanged
  - credit_in with credit == CREDITS and no dec: credit stays CREDITS, credit_err <= 1 for one cycle
- credit_err is 0 in every other cycle.
- Credit arithmetic is CW bits wide. It never underflows, because a grant requires credit != 0.
- The arbiter is flit-level: flits from different VCs interleave freely. Per-VC flit order is preserved.
- Reset values:
  - vc_read_en = 0 (forced while reset is low)
  - link_valid = 0, link_data = 0, link_vc = 0
  - credit_err = 0
  - every credit = CREDITS
  - last = NUM_VC-1, so VC0 has first priority
- Reset mid-stream: all state returns to the reset values immediately. A flit in flight on the link is dropped. The upstream buffers are not popped during reset.

## Timing
- Grant decision and vc_read_en are combinational from vc_empty, credit, last and en in the same cycle. The buffer pops on the same edge that registers the flit.
- Latency is one cycle: a flit granted in cycle t appears on link_data with link_valid = 1 in cycle t+1.
- Throughput is one flit per cycle across all VCs. A single VC with credits and data sustains one flit per cycle.
- A credit_in in cycle t makes the VC eligible in cycle t+1 at the earliest.
- A VC with credit 0 is never granted, even if it is the only non-empty VC.
- en = 0: no grant and no pop. Credits still accept credit_in.

## Test plan
- Reset: assert reset low mid-traffic -> vc_read_en = 0, link_valid = 0, link_data = 0, link_vc = 0, credits = 32. After release, the first grant goes to VC0 when all VCs are non-empty.
- Single-VC credit exhaustion: VC2 always non-empty, no credit_in -> exactly 32 consecutive flits with link_vc = 2, then link_valid = 0. One credit_in[2] pulse -> exactly one more flit, two cycles after the pulse.
- Round-robin fairness: all 4 VCs non-empty with full credits -> link_vc sequence 0,1,2,3,0,1… with link_valid high every cycle. Emptying VC1 gives 0,2,3,0,2…
- Simultaneous events: grant VC0 while credit_in[0] pulses -> credit[0] unchanged (32 stays 32). No credit_err.
- Overflow: VC3 at 32 credits, no grant, credit_in[3] pulse -> credit_err high for exactly one cycle, credit stays 32.
- Data integrity: enqueue distinct patterns 0xA000_000i on VC i -> each link_data matches the expected value for its link_vc, in per-VC FIFO order.
